// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - shared defaults and mode encodings for the CPU clock generator
package clock_gen_pkg;

    localparam int DEF_DEB_BITS = 8;
    localparam int DEF_DIV_BITS = 16;
    localparam int DEF_T_STATES = 5;
    localparam int DEF_T_W      = 3;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/clock_gen_if.sv
// rtl/clock_gen_if.sv - tick and T-state bundle between clock generator and control unit
interface clock_gen_if #(
    parameter int T_STATES = 5,
    parameter int T_W      = 3
);
    logic                tick;
    logic [T_W-1:0]      t_state;
    logic [T_STATES-1:0] t_onehot;
    logic                step_reset;

    modport master (output tick, output t_state, output t_onehot, input step_reset);
    modport slave  (input tick, input t_state, input t_onehot, output step_reset);
endinterface

// File: rtl/clock_gen_btn_debounce.sv
// rtl/clock_gen_btn_debounce.sv - step button synchroniser with saturating hysteresis debounce
module btn_debounce #(
    parameter int DEB_BITS = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic pulse,
    output logic level,
    output logic rise
);
    localparam logic [DEB_BITS-1:0] CNT_MAX = '1;

    logic                sync1;
    logic                sync2;
    logic [DEB_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= pulse;
            sync2 <= sync1;
            if (sync2 && cnt != CNT_MAX) begin
                cnt <= cnt + DEB_BITS'(1);
            end else if (!sync2 && cnt != '0) begin
                cnt <= cnt - DEB_BITS'(1);
            end
            // Level only moves at the counter extremes; in between it holds.
            rise <= 1'b0;
            if (cnt == CNT_MAX) begin
                level <= 1'b1;
                rise  <= !level;
            end else if (cnt == '0) begin
                level <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clock_gen.sv
// rtl/clock_gen.sv - auto/manual tick generator with halt masking and T-state sequencer
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int DEB_BITS = DEF_DEB_BITS,
    parameter int DIV_BITS = DEF_DIV_BITS,
    parameter int T_STATES = DEF_T_STATES,
    parameter int T_W      = DEF_T_W
) (
    input  logic                system_clock,
    input  logic                reset_n,
    input  logic                run_mode,
    input  logic [DIV_BITS-1:0] div_value,
    input  logic                manual_pulse,
    input  logic                halt,
    output logic                btn_level,
    output logic                halted,
    clock_gen_if.master         cpu
);
    logic [DIV_BITS-1:0] div_cnt;
    logic                auto_q;
    logic                man_q;
    logic                btn_rise;
    logic                auto_run;
    logic                tick;
    logic [T_W-1:0]      t_state_q;
    logic [T_W-1:0]      t_next;
    logic [T_STATES-1:0] t_onehot_q;

    btn_debounce #(.DEB_BITS(DEB_BITS)) u_debounce (
        .clk    (system_clock),
        .resetn (reset_n),
        .pulse  (manual_pulse),
        .level  (btn_level),
        .rise   (btn_rise)
    );

    assign auto_run = (run_mode == MODE_AUTO) && !halt;

    // Edges seen during halt or auto mode are dropped here rather than queued.
    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            div_cnt <= '0;
            auto_q  <= 1'b0;
            man_q   <= 1'b0;
            halted  <= 1'b0;
        end else begin
            halted <= halt;
            man_q  <= btn_rise && (run_mode == MODE_MANUAL) && !halt;
            if (auto_run) begin
                auto_q  <= (div_cnt == div_value);
                div_cnt <= (div_cnt == div_value) ? '0 : div_cnt + DIV_BITS'(1);
            end else begin
                auto_q  <= 1'b0;
                div_cnt <= '0;
            end
        end
    end

    assign tick = (auto_q || man_q) && !halt;

    always_comb begin
        t_next = t_state_q + T_W'(1);
        if (cpu.step_reset || t_state_q == T_W'(T_STATES - 1)) begin
            t_next = '0;
        end
    end

    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            t_state_q  <= '0;
            t_onehot_q <= T_STATES'(1);
        end else if (tick) begin
            t_state_q  <= t_next;
            t_onehot_q <= T_STATES'(1) << t_next;
        end
    end

    assign cpu.tick     = tick;
    assign cpu.t_state  = t_state_q;
    assign cpu.t_onehot = t_onehot_q;
endmodule

// File: tb/tb_clock_gen.sv
// tb/tb_clock_gen.sv - directed self-checking bench for clock_gen
module tb_clock_gen;
    logic        system_clock = 1'b0;
    logic        reset_n      = 1'b0;
    logic        run_mode     = 1'b0;
    logic [15:0] div_value    = 16'd0;
    logic        manual_pulse = 1'b0;
    logic        halt         = 1'b0;
    logic        btn_level;
    logic        halted;
    int          checks = 0;
    int          errors = 0;
    int          ticks  = 0;

    clock_gen_if #(.T_STATES(5), .T_W(3)) cpu_if ();

    clock_gen #(.DEB_BITS(4), .DIV_BITS(16), .T_STATES(5), .T_W(3)) dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .run_mode     (run_mode),
        .div_value    (div_value),
        .manual_pulse (manual_pulse),
        .halt         (halt),
        .btn_level    (btn_level),
        .halted       (halted),
        .cpu          (cpu_if)
    );

    always #5 system_clock = ~system_clock;

    task automatic step();
        @(posedge system_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic mode, input logic [15:0] dv);
        reset_n           = 1'b0;
        run_mode          = mode;
        div_value         = dv;
        halt              = 1'b0;
        manual_pulse      = 1'b0;
        cpu_if.step_reset = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic run_count(input int n);
        ticks = 0;
        repeat (n) begin
            step();
            if (cpu_if.tick === 1'b1) ticks++;
        end
    endtask

    initial begin
        int exp_t;
        cpu_if.step_reset = 1'b0;

        // Reset values, then auto mode with div_value=3
        do_reset(1'b1, 16'd3);
        check("rst_tick", cpu_if.tick, 0);
        check("rst_t_state", cpu_if.t_state, 0);
        check("rst_onehot", cpu_if.t_onehot, 1);
        check("rst_btn", btn_level, 0);
        check("rst_halted", halted, 0);
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_t = ((k - 1) / 4) % 5;
            check("div3_tick", cpu_if.tick, (k % 4 == 0));
            check("div3_t_state", cpu_if.t_state, exp_t);
            check("div3_onehot", cpu_if.t_onehot, 32'd1 << exp_t);
        end

        // Halt at t_state=2 with tick every cycle
        do_reset(1'b1, 16'd0);
        step(); step(); step();
        check("halt_pre_t", cpu_if.t_state, 2);
        check("halt_pre_tick", cpu_if.tick, 1);
        halt = 1'b1;
        #1;
        check("halt_mask_tick", cpu_if.tick, 0);
        check("halt_halted_same", halted, 0);
        step();
        check("halt_hold_t", cpu_if.t_state, 2);
        check("halt_halted", halted, 1);
        check("halt_tick_off", cpu_if.tick, 0);
        halt = 1'b0;
        step();
        check("release_tick", cpu_if.tick, 1);
        check("release_t", cpu_if.t_state, 2);
        check("release_halted", halted, 0);
        step();
        check("release_t3", cpu_if.t_state, 3);
        check("release_onehot", cpu_if.t_onehot, 8);

        // step_reset with and without tick
        do_reset(1'b1, 16'd0);
        step(); step(); step();
        check("sr_pre_t", cpu_if.t_state, 2);
        cpu_if.step_reset = 1'b1;
        step();
        check("sr_t0", cpu_if.t_state, 0);
        check("sr_onehot", cpu_if.t_onehot, 1);
        cpu_if.step_reset = 1'b0;
        step();
        check("sr_t1", cpu_if.t_state, 1);
        halt = 1'b1;
        cpu_if.step_reset = 1'b1;
        #1;
        check("sr_notick", cpu_if.tick, 0);
        step();
        check("sr_ignored", cpu_if.t_state, 1);
        halt = 1'b0;
        cpu_if.step_reset = 1'b0;

        // Reset mid-run at t_state=3, divider restarts
        do_reset(1'b1, 16'd1);
        repeat (7) step();
        check("mid_pre_t", cpu_if.t_state, 3);
        reset_n = 1'b0;
        step();
        check("mid_tick", cpu_if.tick, 0);
        check("mid_t", cpu_if.t_state, 0);
        check("mid_onehot", cpu_if.t_onehot, 1);
        check("mid_halted", halted, 0);
        check("mid_btn", btn_level, 0);
        reset_n = 1'b1;
        step();
        check("mid_div_first", cpu_if.tick, 0);
        step();
        check("mid_div_second", cpu_if.tick, 1);

        // Clean manual press: exact debounce latency and single tick
        do_reset(1'b0, 16'd0);
        manual_pulse = 1'b1;
        repeat (17) step();
        check("man_btn_early", btn_level, 0);
        step();
        check("man_btn_rise", btn_level, 1);
        check("man_tick_not_yet", cpu_if.tick, 0);
        step();
        check("man_tick", cpu_if.tick, 1);
        check("man_t_old", cpu_if.t_state, 0);
        step();
        check("man_tick_once", cpu_if.tick, 0);
        check("man_t_new", cpu_if.t_state, 1);
        run_count(20);
        check("man_hold_ticks", ticks, 0);
        manual_pulse = 1'b0;
        run_count(40);
        check("man_release_ticks", ticks, 0);
        check("man_release_btn", btn_level, 0);

        // Glitchy press
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            manual_pulse = (i != 2 && i != 5 && i != 8);
            step();
            if (cpu_if.tick === 1'b1) ticks++;
        end
        check("glitch_ticks", ticks, 1);
        check("glitch_btn", btn_level, 1);
        manual_pulse = 1'b0;
        run_count(40);
        check("glitch_release_ticks", ticks, 0);

        // Press during halt is discarded
        do_reset(1'b0, 16'd0);
        halt = 1'b1;
        manual_pulse = 1'b1;
        run_count(30);
        check("halt_press_btn", btn_level, 1);
        check("halt_press_ticks", ticks, 0);
        halt = 1'b0;
        run_count(10);
        check("halt_after_ticks", ticks, 0);
        manual_pulse = 1'b0;
        run_count(40);

        // Press in auto mode is discarded
        do_reset(1'b1, 16'd1000);
        manual_pulse = 1'b1;
        run_count(30);
        check("auto_press_ticks", ticks, 0);
        run_mode = 1'b0;
        run_count(10);
        check("auto_then_manual_ticks", ticks, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
